// File: rtl/osc_freq_meter_pkg.sv
// Shared types and default widths for the oscillator frequency meter.
// No logic; imported by osc_sync and osc_freq_meter.
package osc_freq_meter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int CNT_W_DEF       = 16;
    localparam int WIN_W_DEF       = 16;
    localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/osc_sync.sv
// N-stage resettable synchronizer for an asynchronous oscillator phase (N legal 2..4).
// Latency: N clk cycles from d to q. No backpressure; samples every cycle.
module osc_sync
    import osc_freq_meter_pkg::*;
#(
    parameter int N = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [N-1:0] sync_q;
    logic [N-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[N-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[N-1];

endmodule

// File: rtl/osc_freq_meter.sv
// Counts rising edges of osc_in over a win_len-cycle gate; OSC_FREQ_METER_CTRL_TAG_EN adds ctrl tagging.
// Latency: res_valid win_len+2 cycles after an accepted start (1 cycle when win_len=0).
// Backpressure: result held in DONE until res_ready; start ignored while busy, never queued.
module osc_freq_meter
    import osc_freq_meter_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int WIN_W       = WIN_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             osc_in,
    input  logic             start,
    input  logic [WIN_W-1:0] win_len,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] res_count,
    output logic             res_ovf
`ifdef OSC_FREQ_METER_CTRL_TAG_EN
    ,
    input  logic [1:0]       ctrl,
    output logic [1:0]       res_ctrl,
    output logic             res_ctrl_chg
`endif
);

    state_t           state_q, state_d;
    logic             s;
    logic             s_prev_q, s_prev_d;
    logic             edge_det;
    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    osc_sync #(.N(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (osc_in),
        .q   (s)
    );

    assign edge_det = s & ~s_prev_q;

    always_comb begin
        state_d   = state_q;
        s_prev_d  = s;
        win_cnt_d = win_cnt_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d = '0;
                    ovf_d = 1'b0;
                    if (win_len != '0) begin
                        win_cnt_d = win_len;
                        state_d   = ARM;
                    end else begin
                        state_d   = DONE;
                    end
                end
            end
            // One dead cycle so s_prev is settled before the gate opens.
            ARM: state_d = COUNT;
            COUNT: begin
                if (edge_det) begin
                    if (&cnt_q) begin
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                win_cnt_d = win_cnt_q - WIN_W'(1);
                if (win_cnt_q == WIN_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            s_prev_q  <= 1'b0;
            win_cnt_q <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            s_prev_q  <= s_prev_d;
            win_cnt_q <= win_cnt_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign res_valid = (state_q == DONE);
    assign res_count = cnt_q;
    assign res_ovf   = ovf_q;

`ifdef OSC_FREQ_METER_CTRL_TAG_EN
    logic [1:0] ctrl_q, ctrl_d;
    logic       chg_q, chg_d;

    always_comb begin
        ctrl_d = ctrl_q;
        chg_d  = chg_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    ctrl_d = ctrl;
                    chg_d  = 1'b0;
                end
            end
            ARM, COUNT: begin
                if (ctrl != ctrl_q) begin
                    chg_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q <= 2'b00;
            chg_q  <= 1'b0;
        end else begin
            ctrl_q <= ctrl_d;
            chg_q  <= chg_d;
        end
    end

    assign res_ctrl     = ctrl_q;
    assign res_ctrl_chg = chg_q;
`endif

endmodule

// File: tb/tb_osc_freq_meter.sv
// Bench for osc_freq_meter: a 16-bit and a 4-bit counter instance share stimulus;
// expected counts come from the recorded osc_in sample history.
module tb_osc_freq_meter;

    localparam int NS = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        osc_in = 1'b0;
    logic        start;
    logic        res_ready;
    logic [15:0] win_len;

    logic        busy, res_valid, res_ovf;
    logic [15:0] res_count;
    logic        busy_s, res_valid_s, res_ovf_s;
    logic [3:0]  res_count_s;
`ifdef OSC_FREQ_METER_CTRL_TAG_EN
    logic [1:0]  ctrl;
    logic [1:0]  res_ctrl, res_ctrl_s;
    logic        res_ctrl_chg, res_ctrl_chg_s;
`endif

    int checks = 0;
    int errors = 0;
    bit hist[$];
    int osc_half = 5;
    int osc_ph = 0;

    osc_freq_meter #(.CNT_W(16), .WIN_W(16), .SYNC_STAGES(NS)) u_dut (
        .clk(clk), .rst(rst), .osc_in(osc_in), .start(start), .win_len(win_len),
        .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
        .res_count(res_count), .res_ovf(res_ovf)
`ifdef OSC_FREQ_METER_CTRL_TAG_EN
        , .ctrl(ctrl), .res_ctrl(res_ctrl), .res_ctrl_chg(res_ctrl_chg)
`endif
    );

    osc_freq_meter #(.CNT_W(4), .WIN_W(16), .SYNC_STAGES(NS)) u_dut_sat (
        .clk(clk), .rst(rst), .osc_in(osc_in), .start(start), .win_len(win_len),
        .busy(busy_s), .res_valid(res_valid_s), .res_ready(res_ready),
        .res_count(res_count_s), .res_ovf(res_ovf_s)
`ifdef OSC_FREQ_METER_CTRL_TAG_EN
        , .ctrl(ctrl), .res_ctrl(res_ctrl_s), .res_ctrl_chg(res_ctrl_chg_s)
`endif
    );

    always #5 clk = ~clk;

    // Value of osc_in seen at each rising clk edge, indexed by edge number.
    always @(posedge clk) hist.push_back(osc_in);

    always @(negedge clk) begin
        if (osc_ph >= osc_half - 1) begin
            osc_ph = 0;
            osc_in = ~osc_in;
        end else begin
            osc_ph++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Rising edges of the synchronized input that fall inside the gate of a
    // measurement whose start was taken at clk edge a.
    function automatic int model_edges(input int a, input int win);
        int n = 0;
        for (int j = a + 2; j <= a + win + 1; j++) begin
            if (hist[j-NS] && !hist[j-NS-1]) n++;
        end
        return n;
    endfunction

    task automatic wait_valid(input int bound);
        int i = 0;
        while (!res_valid && i < bound) begin
            @(negedge clk);
            i++;
        end
    endtask

    task automatic measure(input int win, input int hold);
        int a, n, e16, e4;
`ifdef OSC_FREQ_METER_CTRL_TAG_EN
        logic [1:0] c;
        c = 2'($urandom);
        ctrl = c;
`endif
        win_len = 16'(win);
        start = 1'b1;
        a = hist.size();
        @(negedge clk);
        start = 1'b0;
        win_len = 16'($urandom);
        wait_valid(win + 50);
        chk("latency", 32'(hist.size() - a), (win == 0) ? 1 : win + 2);
        n = model_edges(a, win);
        e16 = (n > 65535) ? 65535 : n;
        e4 = (n > 15) ? 15 : n;
        chk("valid", 32'(res_valid), 1);
        chk("valid_sat", 32'(res_valid_s), 1);
        chk("count16", 32'(res_count), e16);
        chk("ovf16", 32'(res_ovf), (n > 65535) ? 1 : 0);
        chk("count4", 32'(res_count_s), e4);
        chk("ovf4", 32'(res_ovf_s), (n > 15) ? 1 : 0);
`ifdef OSC_FREQ_METER_CTRL_TAG_EN
        chk("res_ctrl", 32'(res_ctrl), 32'(c));
        chk("ctrl_chg", 32'(res_ctrl_chg), 0);
`endif
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", 32'(res_valid), 1);
            chk("hold_count", 32'(res_count), e16);
            chk("hold_ovf4", 32'(res_ovf_s), (n > 15) ? 1 : 0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("drop_valid", 32'(res_valid), 0);
        chk("drop_valid_sat", 32'(res_valid_s), 0);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_busy_sat", 32'(busy_s), 0);
        chk("keep_count", 32'(res_count), e16);
        chk("keep_count4", 32'(res_count_s), e4);
    endtask

    initial begin
        int  a;
        bit  seen;
        rst = 1'b1;
        start = 1'b0;
        res_ready = 1'b0;
        win_len = '0;
`ifdef OSC_FREQ_METER_CTRL_TAG_EN
        ctrl = 2'b00;
`endif
        osc_half = 2;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_valid", 32'(res_valid), 0);
            chk("rst_count", 32'(res_count), 0);
            chk("rst_ovf", 32'(res_ovf), 0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", 32'(busy), 0);
        chk("post_rst_valid", 32'(res_valid), 0);
        chk("post_rst_count", 32'(res_count), 0);
        repeat (6) @(negedge clk);

        osc_half = 5;
        measure(100, 5);

        // Zero window, then starts during DONE and alongside res_ready are dropped.
        win_len = 16'd0;
        start = 1'b1;
        a = hist.size();
        @(negedge clk);
        chk("zero_latency", 32'(hist.size() - a), 1);
        chk("zero_valid", 32'(res_valid), 1);
        chk("zero_count", 32'(res_count), 0);
        win_len = 16'd50;
        @(negedge clk);
        start = 1'b0;
        chk("done_start_valid", 32'(res_valid), 1);
        chk("done_start_busy", 32'(busy), 1);
        start = 1'b1;
        res_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        res_ready = 1'b0;
        chk("ack_valid", 32'(res_valid), 0);
        chk("ack_busy", 32'(busy), 0);
        @(negedge clk);
        chk("no_queue_busy", 32'(busy), 0);

        osc_half = 2;
        measure(200, 0);
        osc_half = 3;
        measure(60, 20);
        osc_half = 4;
        measure(1, 1);

        // Reset in the fifth COUNT cycle abandons the run.
        osc_half = 4;
        win_len = 16'd100;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_busy_pre", 32'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_valid", 32'(res_valid), 0);
        chk("mid_rst_count", 32'(res_count), 0);
        chk("mid_rst_ovf", 32'(res_ovf), 0);
        seen = 1'b0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (res_valid || busy) seen = 1'b1;
        end
        chk("mid_rst_no_result", 32'(seen), 0);

        for (int r = 0; r < 8; r++) begin
            osc_half = $urandom_range(2, 9);
            measure($urandom_range(1, 300), $urandom_range(0, 5));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

`ifdef OSC_FREQ_METER_CTRL_TAG_EN
        osc_half = 3;
        ctrl = 2'b01;
        win_len = 16'd80;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        ctrl = 2'b00;
        repeat (3) @(negedge clk);
        ctrl = 2'b01;
        wait_valid(150);
        chk("tag_valid", 32'(res_valid), 1);
        chk("tag_ctrl", 32'(res_ctrl), 1);
        chk("tag_chg", 32'(res_ctrl_chg), 1);
        chk("tag_ctrl_sat", 32'(res_ctrl_s), 1);
        chk("tag_chg_sat", 32'(res_ctrl_chg_s), 1);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("tag_hold_chg", 32'(res_ctrl_chg), 1);
        measure(50, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
